qspi_tx_shifter: RTL

Serialiser between the 32-bit transmit FIFO (`fifo_tx`) and the QSPI pad interface. It pops words from the FIFO and shifts them MSB-first onto 1, 2 or 4 data lines, one beat per shift tick from the SCLK generator. It stalls the SCLK generator when no data is available, and it pulses `done_o` after the programmed byte count has been driven.

---
 rtl/qspi_pkg.sv | 31 +++
 rtl/qspi_tx_shifter_if.sv | 26 ++
 rtl/qspi_tx_shifter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared constants, state encoding and lane helpers for the QSPI transmit shifter
package qspi_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] LANES_X1 = 2'd0;
    localparam logic [1:0] LANES_X2 = 2'd1;
    localparam logic [1:0] LANES_X4 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Reserved lane code 3 falls back to single-lane operation.
    function automatic logic [2:0] lane_step(input logic [1:0] lanes);
        case (lanes)
            LANES_X2: return 3'd2;
            LANES_X4: return 3'd4;
            default:  return 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] step);
        return 4'((5'd1 << step) - 5'd1);
    endfunction

endpackage

// File: rtl/qspi_tx_shifter_if.sv
// rtl/qspi_tx_shifter_if.sv - FIFO pop port and pad drive bundle of the QSPI transmit shifter
interface qspi_tx_shifter_if
    import qspi_pkg::*;
;
    logic              fifo_rd_en_o;
    logic [WORD_W-1:0] fifo_rd_data_i;
    logic              fifo_empty_i;
    logic [3:0]        io_o;
    logic [3:0]        io_oe_o;

    modport master (
        output fifo_rd_en_o,
        output io_o,
        output io_oe_o,
        input  fifo_rd_data_i,
        input  fifo_empty_i
    );

    modport slave (
        input  fifo_rd_en_o,
        input  io_o,
        input  io_oe_o,
        output fifo_rd_data_i,
        output fifo_empty_i
    );
endinterface

// File: rtl/qspi_tx_shifter.sv
// rtl/qspi_tx_shifter.sv - pops FIFO words and shifts them MSB-first onto 1/2/4 QSPI lanes
// QSPI_TX_PREFETCH_EN adds a holding register that hides the word-boundary FETCH/LOAD bubble.
module qspi_tx_shifter
    import qspi_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic [1:0]           lanes_i,
    input  logic                 shift_tick_i,
    qspi_tx_shifter_if.master    fifo_if,
    output logic                 stall_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 underrun_o
);

    localparam int CNT_W = LEN_W + 3;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  bits_q, bits_d;
    logic [5:0]        wbits_q, wbits_d;
    logic [2:0]        step_q, step_d;
    logic              underrun_q, underrun_d;
    logic [CNT_W-1:0]  bits_next;
    logic [5:0]        wbits_next;
    logic [3:0]        mask;
    logic [3:0]        top;

`ifdef QSPI_TX_PREFETCH_EN
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              pend_q, pend_d;
    logic              pref_rd;
`endif

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bits_d       = bits_q;
        wbits_d      = wbits_q;
        step_d       = step_q;
        underrun_d   = underrun_q;
        fifo_if.fifo_rd_en_o = 1'b0;
        bits_next    = bits_q - CNT_W'(step_q);
        wbits_next   = wbits_q - 6'(step_q);
`ifdef QSPI_TX_PREFETCH_EN
        hold_d       = hold_q;
        hold_vld_d   = hold_vld_q;
        pend_d       = 1'b0;
        pref_rd      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    underrun_d = 1'b0;
`ifdef QSPI_TX_PREFETCH_EN
                    hold_vld_d = 1'b0;
`endif
                    if (len_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        bits_d  = {len_i, 3'b000};
                        step_d  = lane_step(lanes_i);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (!fifo_if.fifo_empty_i) begin
                    fifo_if.fifo_rd_en_o = 1'b1;
                    state_d = ST_LOAD;
                end else begin
                    underrun_d = 1'b1;
                end
            end
            ST_LOAD: begin
                sr_d    = fifo_if.fifo_rd_data_i;
                wbits_d = 6'd32;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
`ifdef QSPI_TX_PREFETCH_EN
                // Only pop a word that the remaining count actually needs.
                pref_rd = !hold_vld_q && !pend_q && !fifo_if.fifo_empty_i &&
                          (bits_q > CNT_W'(wbits_q));
                pend_d  = pref_rd;
                fifo_if.fifo_rd_en_o = pref_rd;
                if (pend_q) begin
                    hold_d     = fifo_if.fifo_rd_data_i;
                    hold_vld_d = 1'b1;
                end
`endif
                if (shift_tick_i) begin
                    sr_d    = sr_q << step_q;
                    bits_d  = bits_next;
                    wbits_d = wbits_next;
                    if (bits_next == '0) begin
                        state_d = ST_DONE;
                    end else if (wbits_next == '0) begin
`ifdef QSPI_TX_PREFETCH_EN
                        if (hold_vld_q) begin
                            sr_d       = hold_q;
                            wbits_d    = 6'd32;
                            hold_vld_d = 1'b0;
                        end else if (pend_q) begin
                            sr_d       = fifo_if.fifo_rd_data_i;
                            wbits_d    = 6'd32;
                            hold_vld_d = 1'b0;
                        end else begin
                            state_d = pref_rd ? ST_LOAD : ST_FETCH;
                        end
`else
                        state_d = ST_FETCH;
`endif
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            bits_q     <= '0;
            wbits_q    <= '0;
            step_q     <= 3'd1;
            underrun_q <= 1'b0;
`ifdef QSPI_TX_PREFETCH_EN
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            pend_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bits_q     <= bits_d;
            wbits_q    <= wbits_d;
            step_q     <= step_d;
            underrun_q <= underrun_d;
`ifdef QSPI_TX_PREFETCH_EN
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            pend_q     <= pend_d;
`endif
        end
    end

    // Align the active lanes of the top nibble down to io[0].
    assign mask    = lane_mask(step_q);
    assign top     = sr_q[WORD_W-1 -: 4];
    assign stall_o = (state_q == ST_FETCH) || (state_q == ST_LOAD);
    assign busy_o  = stall_o || (state_q == ST_SHIFT);
    assign done_o  = (state_q == ST_DONE);
    assign underrun_o      = underrun_q;
    assign fifo_if.io_o    = (state_q == ST_SHIFT) ? ((top >> (3'd4 - step_q)) & mask) : 4'd0;
    assign fifo_if.io_oe_o = busy_o ? mask : 4'd0;

endmodule
